// File: rtl/mux_scan.sv
// Channel multiplexer with manual select and timed auto-scan.
// Data_Out and Ch_Out are registered from the same next-channel value, so they always agree.
module mux_scan #(
    parameter int WIDTH  = 1,
    parameter int CH_NUM = 8,
    parameter int SEL_W  = 3,
    parameter int DWELL  = 50_000_000
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    CSn,
    input  logic                    Mode,
    input  logic [SEL_W-1:0]        SW_In,
    input  logic [CH_NUM*WIDTH-1:0] Data_In,
    output logic [WIDTH-1:0]        Data_Out,
    output logic [SEL_W-1:0]        Ch_Out,
    output logic                    Ch_Valid
);

    localparam int CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int CH_PAD = 1 << SEL_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CH_NUM - 1);
    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CH_NUM);

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        AUTO
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] ch_nxt;
    logic [WIDTH-1:0] data_nxt;

    // Channel table padded to the full select range so any index is in bounds.
    logic [WIDTH-1:0] chan [CH_PAD];

    for (genvar i = 0; i < CH_PAD; i++) begin : g_chan
        if (i < CH_NUM) begin : g_used
            assign chan[i] = Data_In[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[i] = '0;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = CSn ? IDLE : (Mode ? AUTO : MANUAL);
        cnt_nxt   = '0;
        ch_nxt    = Ch_Out;

        case (state_nxt)
            MANUAL: begin
                if ({1'b0, SW_In} < CH_LIMIT) begin
                    ch_nxt = SW_In;
                end
            end
            AUTO: begin
                // The entry edge only restarts the dwell; counting begins on the next edge.
                if (state == AUTO) begin
                    if (cnt == CNT_LAST) begin
                        ch_nxt = (Ch_Out == CH_LAST) ? '0 : Ch_Out + SEL_W'(1);
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        data_nxt = (state_nxt == IDLE) ? '0 : chan[ch_nxt];
    end

    // NOTE: reset is synchronous, sampled only at the clock edge; all state uses non-blocking assignment.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state    <= IDLE;
            cnt      <= '0;
            Ch_Out   <= '0;
            Data_Out <= '0;
            Ch_Valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            Ch_Out   <= ch_nxt;
            Data_Out <= data_nxt;
            Ch_Valid <= (ch_nxt != Ch_Out);
        end
    end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter WIDTH, default 1, data bits per channel.
REQ-002 Parameter CH_NUM, default 8, number of input channels (2..256).
REQ-003 Parameter SEL_W, default 3, select/channel index width; SHALL satisfy 2**SEL_W >= CH_NUM.
REQ-004 Parameter DWELL, default 50_000_000, clocks per channel in auto-scan mode (>= 1).
REQ-005 CLK  input  1  single clock; all state updates on its rising edge.
REQ-006 RSTn  input  1  reset, synchronous, active-low.
REQ-007 CSn  input  1  chip select, active-low; high forces IDLE.
REQ-008 Mode  input  1  0 = manual select, 1 = auto-scan.
REQ-009 SW_In  input  SEL_W  manual channel index.
REQ-010 Data_In  input  CH_NUM*WIDTH  flattened channels; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-011 Data_Out  output  WIDTH  registered selected data.
REQ-012 Ch_Out  output  SEL_W  registered index of the channel currently driving Data_Out.
REQ-013 Ch_Valid  output  1  one-cycle pulse on channel change.

Function
REQ-014 The block SHALL hold state IDLE, MANUAL or AUTO in a registered state machine, evaluated every rising CLK edge.
REQ-015 Next state SHALL be: CSn=1 -> IDLE; else Mode=0 -> MANUAL; else AUTO; CSn has priority over Mode.
REQ-016 IDLE: Data_Out SHALL be 0, Ch_Out SHALL hold, dwell counter SHALL be 0, Ch_Valid SHALL be 0.
REQ-017 MANUAL: next channel SHALL equal SW_In when SW_In < CH_NUM; SW_In >= CH_NUM SHALL leave channel unchanged.
REQ-018 AUTO: dwell counter SHALL count 0..DWELL-1; at DWELL-1 it SHALL reload 0 and channel SHALL advance by 1.
REQ-019 AUTO channel SHALL wrap from CH_NUM-1 to 0 (no visit to indices >= CH_NUM even when CH_NUM < 2**SEL_W).
REQ-020 Entry into AUTO from any state SHALL start at the current Ch_Out with counter 0; first advance occurs DWELL clocks after entry edge.
REQ-021 Any Mode or CSn change SHALL clear the dwell counter; counter SHALL never be nonzero outside AUTO.
REQ-022 DWELL=1 SHALL advance the channel every clock in AUTO.
REQ-023 Data_Out SHALL be registered from the Data_In slice of the next-channel value, so Data_Out and Ch_Out are always coherent on the same cycle.
REQ-024 Latency: Data_In or SW_In change -> Data_Out/Ch_Out change SHALL be exactly 1 clock (non-IDLE states).
REQ-025 Ch_Valid SHALL be 1 for exactly the cycle after an edge where Ch_Out took a value different from its previous value; held channel SHALL give Ch_Valid=0.
REQ-026 Dwell counter width SHALL be sized from DWELL (clog2), no overflow for any legal DWELL.

Reset
REQ-027 RSTn=0 at a rising edge SHALL set state IDLE, Data_Out=0, Ch_Out=0, Ch_Valid=0, counter=0, regardless of CSn/Mode.
REQ-028 Reset asserted mid-dwell SHALL discard progress; after release AUTO SHALL restart at channel 0 with full DWELL.
REQ-029 RSTn SHALL have no effect between clock edges (synchronous only).

Verification (WIDTH=4, CH_NUM=8, DWELL=4 unless stated)
REQ-030 Reset: hold RSTn=0 3 clocks with CSn=0, Mode=1 -> Data_Out=0, Ch_Out=0, Ch_Valid=0 throughout.
REQ-031 Manual: CSn=0, Mode=0, Data_In channel i = i+1, SW_In 5 -> next edge Data_Out=6, Ch_Out=5, Ch_Valid pulse 1 cycle; SW_In held -> Ch_Valid stays 0.
REQ-032 Auto wrap: Mode=1 from Ch_Out=6 -> Ch_Out 6 for 4 clocks, then 7 for 4, then 0; Ch_Valid pulses at each step.
REQ-033 Chip select: CSn=1 mid-dwell at Ch_Out=3 -> Data_Out=0, Ch_Out=3; CSn=0 again -> Ch_Out 3 for full 4 clocks before 4.
REQ-034 Illegal index: CH_NUM=6, Mode=0, SW_In=2 then 7 -> Ch_Out stays 2, no Ch_Valid; Mode=1 from 5 -> wraps to 0.
REQ-035 Mid-operation reset and DWELL=1: RSTn=0 one clock during AUTO at Ch_Out=4 -> Ch_Out=0; with DWELL=1 channel increments every clock 0,1,...,7,0.
